// File: rtl/pcileech_ft601_devmodel.sv
// ----------------------------------------------------------------------------
// pcileech_ft601_devmodel
//
// Behavioural but synthesizable stand-in for the FT601 chip on the
// FT245-style 32-bit synchronous FIFO bus. The FPGA-side FT601 controller
// talks to this block exactly as it would talk to silicon. A simple host word
// interface replaces the USB side: it fills the host-to-FPGA (RX) FIFO and
// drains the FPGA-to-host (TX) FIFO. Intended for loopback builds and benches.
//
// Ports
//   clk, rst          : shared bus clock, synchronous active-high reset
//   ft_data_in, ft_be : data and byte enables driven by the FPGA
//   ft_oe_n, ft_rd_n,
//   ft_wr_n, ft_siwu_n: FPGA bus strobes (SIWU has no effect on this model)
//   ft_data_out       : word the device drives onto the bus
//   ft_data_oe        : device owns the bus (tristate enable)
//   ft_rxf_n          : low while the device offers RX data
//   ft_txe_n          : low while the device can accept TX data
//   host_din, host_din_wr_en, host_din_full          : RX FIFO push side
//   host_rd_en, host_dout, host_dout_valid,
//   host_tx_empty                                    : TX FIFO pop side
//   err_flags         : sticky protocol errors
//                       [0] RD_N low while OE_N high
//                       [1] WR_N low while OE_N low
//                       [2] TX write dropped because the FIFO was full
//                       [3] TX write with partial byte enables
// ----------------------------------------------------------------------------
module pcileech_ft601_devmodel #(
   parameter int RX_DEPTH   = 16,
   parameter int TX_DEPTH   = 16,
   parameter int TXE_SLACK  = 4,
   parameter int MAX_BURST  = 8,
   parameter int GAP_CYCLES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ft_data_in,
   input  logic [3:0]  ft_be,
   input  logic        ft_oe_n,
   input  logic        ft_rd_n,
   input  logic        ft_wr_n,
   input  logic        ft_siwu_n,
   output logic [31:0] ft_data_out,
   output logic        ft_data_oe,
   output logic        ft_rxf_n,
   output logic        ft_txe_n,
   input  logic [31:0] host_din,
   input  logic        host_din_wr_en,
   output logic        host_din_full,
   input  logic        host_rd_en,
   output logic [31:0] host_dout,
   output logic        host_dout_valid,
   output logic        host_tx_empty,
   output logic [3:0]  err_flags
);

   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int BC_W  = $clog2(MAX_BURST + 1);
   localparam int GC_W  = $clog2(GAP_CYCLES + 1);

   typedef logic [RX_AW-1:0] rx_ptr_t;
   typedef logic [RX_AW:0]   rx_cnt_t;
   typedef logic [TX_AW-1:0] tx_ptr_t;
   typedef logic [TX_AW:0]   tx_cnt_t;
   typedef logic [BC_W-1:0]  burst_t;
   typedef logic [GC_W-1:0]  gap_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_READY,
      RX_GAP
   } rx_state_t;

   localparam rx_cnt_t RX_FULL    = rx_cnt_t'(RX_DEPTH);
   localparam tx_cnt_t TX_FULL    = tx_cnt_t'(TX_DEPTH);
   localparam tx_cnt_t TX_SLACK   = tx_cnt_t'(TXE_SLACK);
   localparam burst_t  BURST_LAST = burst_t'(MAX_BURST - 1);
   localparam gap_t    GAP_LAST   = gap_t'(GAP_CYCLES - 1);

   // RX side storage and control
   logic [31:0] rx_mem [RX_DEPTH];
   rx_ptr_t     rx_wr_ptr;
   rx_ptr_t     rx_rd_ptr;
   rx_cnt_t     rx_count;
   rx_cnt_t     rx_count_next;
   logic        rx_push;
   logic        rx_pop;
   rx_state_t   rx_state;
   rx_state_t   rx_state_next;
   burst_t      burst_cnt;
   gap_t        gap_cnt;

   // TX side storage and control
   logic [31:0] tx_mem [TX_DEPTH];
   tx_ptr_t     tx_wr_ptr;
   tx_ptr_t     tx_rd_ptr;
   tx_cnt_t     tx_count;
   tx_cnt_t     tx_count_next;
   tx_cnt_t     tx_free_next;
   logic        tx_req;
   logic        tx_push;
   logic        tx_pop;
   logic        tx_overflow;

   logic [3:0]  err_q;

   // SIWU is accepted on the pin list but has no effect on this model.
   logic        unused_siwu;
   assign unused_siwu = ft_siwu_n;

   // The device drives the bus whenever the controller enables its outputs;
   // data comes straight from the registered read pointer so a new word shows
   // up one cycle after each pop.
   assign ft_data_oe  = !ft_oe_n;
   assign ft_data_out = rx_mem[rx_rd_ptr];
   assign err_flags   = err_q;

   // A pop needs the full read handshake and the FSM advertising data. A push
   // at full is still taken when a pop frees a slot on the same edge.
   assign rx_pop  = !ft_oe_n && !ft_rd_n && (rx_count != '0) && (rx_state == RX_READY);
   assign rx_push = host_din_wr_en && ((rx_count != RX_FULL) || rx_pop);

   // TX writes beyond capacity are dropped rather than overwriting data.
   assign tx_req      = !ft_wr_n;
   assign tx_overflow = tx_req && (tx_count == TX_FULL);
   assign tx_push     = tx_req && !tx_overflow;
   assign tx_pop      = host_rd_en && (tx_count != '0);

   // Occupancy after this edge; every registered flag is derived from these
   // so the flags line up with the count the next cycle will see.
   always_comb begin
      rx_count_next = rx_count;
      case ({rx_push, rx_pop})
         2'b10:   rx_count_next = rx_count + rx_cnt_t'(1);
         2'b01:   rx_count_next = rx_count - rx_cnt_t'(1);
         default: rx_count_next = rx_count;
      endcase
      tx_count_next = tx_count;
      case ({tx_push, tx_pop})
         2'b10:   tx_count_next = tx_count + tx_cnt_t'(1);
         2'b01:   tx_count_next = tx_count - tx_cnt_t'(1);
         default: tx_count_next = tx_count;
      endcase
      tx_free_next = TX_FULL - tx_count_next;
   end

   // RX advertising state. A completed burst always forces a gap, even when
   // that pop also empties the FIFO. At the end of the gap the FSM passes
   // through idle without spending a cycle there, so RXF_N stays high for
   // exactly GAP_CYCLES cycles when data is still waiting.
   always_comb begin
      rx_state_next = rx_state;
      case (rx_state)
         RX_IDLE: begin
            if (rx_count_next != '0) begin
               rx_state_next = RX_READY;
            end
         end
         RX_READY: begin
            if (rx_pop && (burst_cnt == BURST_LAST)) begin
               rx_state_next = RX_GAP;
            end else if (rx_count_next == '0) begin
               rx_state_next = RX_IDLE;
            end
         end
         RX_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               rx_state_next = (rx_count_next != '0) ? RX_READY : RX_IDLE;
            end
         end
         default: rx_state_next = RX_IDLE;
      endcase
   end

   // RX FIFO, burst/gap counters and RXF_N. The burst count restarts whenever
   // the FSM leaves the ready state; the gap counter only runs while the FSM
   // stays in the gap so a later gap always starts from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state      <= RX_IDLE;
         rx_wr_ptr     <= '0;
         rx_rd_ptr     <= '0;
         rx_count      <= '0;
         burst_cnt     <= '0;
         gap_cnt       <= '0;
         ft_rxf_n      <= 1'b1;
         host_din_full <= 1'b0;
         for (int i = 0; i < RX_DEPTH; i++) begin
            rx_mem[i] <= '0;
         end
      end else begin
         rx_state      <= rx_state_next;
         rx_count      <= rx_count_next;
         ft_rxf_n      <= (rx_state_next != RX_READY);
         host_din_full <= (rx_count_next == RX_FULL);
         if (rx_push) begin
            rx_mem[rx_wr_ptr] <= host_din;
            rx_wr_ptr         <= rx_wr_ptr + rx_ptr_t'(1);
         end
         if (rx_pop) begin
            rx_rd_ptr <= rx_rd_ptr + rx_ptr_t'(1);
         end
         if (rx_state_next != RX_READY) begin
            burst_cnt <= '0;
         end else if (rx_pop) begin
            burst_cnt <= burst_cnt + burst_t'(1);
         end
         if ((rx_state == RX_GAP) && (rx_state_next == RX_GAP)) begin
            gap_cnt <= gap_cnt + gap_t'(1);
         end else begin
            gap_cnt <= '0;
         end
      end
   end

   // TX storage has no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && tx_push) begin
         tx_mem[tx_wr_ptr] <= ft_data_in;
      end
   end

   // TX pointers, host pop register and TXE_N. TXE_N rises while TXE_SLACK-1
   // entries remain free so strobes already in flight in the controller still
   // land in the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr_ptr       <= '0;
         tx_rd_ptr       <= '0;
         tx_count        <= '0;
         ft_txe_n        <= 1'b1;
         host_tx_empty   <= 1'b1;
         host_dout       <= '0;
         host_dout_valid <= 1'b0;
      end else begin
         tx_count        <= tx_count_next;
         ft_txe_n        <= (tx_free_next < TX_SLACK);
         host_tx_empty   <= (tx_count_next == '0);
         host_dout_valid <= tx_pop;
         if (tx_push) begin
            tx_wr_ptr <= tx_wr_ptr + tx_ptr_t'(1);
         end
         if (tx_pop) begin
            host_dout <= tx_mem[tx_rd_ptr];
            tx_rd_ptr <= tx_rd_ptr + tx_ptr_t'(1);
         end
      end
   end

   // Sticky protocol error flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= '0;
      end else begin
         err_q <= err_q | {tx_req && (ft_be != 4'hF),
                           tx_overflow,
                           !ft_wr_n && !ft_oe_n,
                           !ft_rd_n && ft_oe_n};
      end
   end

endmodule

// File: tb/tb_pcileech_ft601_devmodel.sv
// ----------------------------------------------------------------------------
// tb_pcileech_ft601_devmodel
//
// Drives directed bus/host sequences followed by a randomized phase. A queue
// based reference model predicts every word leaving the device and the state
// of the status outputs; a separate monitor compares on each bus handshake or
// host_dout_valid pulse, and checks the status outputs every cycle.
// ----------------------------------------------------------------------------
module tb_pcileech_ft601_devmodel;

   localparam int RX_DEPTH   = 16;
   localparam int TX_DEPTH   = 16;
   localparam int TXE_SLACK  = 4;
   localparam int MAX_BURST  = 8;
   localparam int GAP_CYCLES = 3;

   logic        clk;
   logic        rst;
   logic [31:0] ft_data_in;
   logic [3:0]  ft_be;
   logic        ft_oe_n;
   logic        ft_rd_n;
   logic        ft_wr_n;
   logic        ft_siwu_n;
   logic [31:0] ft_data_out;
   logic        ft_data_oe;
   logic        ft_rxf_n;
   logic        ft_txe_n;
   logic [31:0] host_din;
   logic        host_din_wr_en;
   logic        host_din_full;
   logic        host_rd_en;
   logic [31:0] host_dout;
   logic        host_dout_valid;
   logic        host_tx_empty;
   logic [3:0]  err_flags;

   int checks   = 0;
   int failures = 0;

   // Reference model: FIFO contents as queues plus burst/gap bookkeeping.
   logic [31:0] m_rxq[$];
   logic [31:0] m_txq[$];
   logic [31:0] exp_rx[$];
   logic [31:0] exp_tx[$];
   bit          m_known      = 0;
   bit          m_just_reset = 0;
   bit          m_rxf_low    = 0;
   int          m_burst      = 0;
   int          m_gap        = 0;
   logic [3:0]  m_err        = '0;
   bit          m_txe_n      = 1;
   bit          m_full       = 0;
   bit          m_empty      = 1;

   // Expected outputs for the cycle currently on the bus.
   bit          s_known      = 0;
   bit          s_just_reset = 0;
   bit          s_rxf_n      = 1;
   bit          s_txe_n      = 1;
   bit          s_full       = 0;
   bit          s_empty      = 1;
   logic [3:0]  s_err        = '0;

   pcileech_ft601_devmodel #(
      .RX_DEPTH   (RX_DEPTH),
      .TX_DEPTH   (TX_DEPTH),
      .TXE_SLACK  (TXE_SLACK),
      .MAX_BURST  (MAX_BURST),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .ft_data_in      (ft_data_in),
      .ft_be           (ft_be),
      .ft_oe_n         (ft_oe_n),
      .ft_rd_n         (ft_rd_n),
      .ft_wr_n         (ft_wr_n),
      .ft_siwu_n       (ft_siwu_n),
      .ft_data_out     (ft_data_out),
      .ft_data_oe      (ft_data_oe),
      .ft_rxf_n        (ft_rxf_n),
      .ft_txe_n        (ft_txe_n),
      .host_din        (host_din),
      .host_din_wr_en  (host_din_wr_en),
      .host_din_full   (host_din_full),
      .host_rd_en      (host_rd_en),
      .host_dout       (host_dout),
      .host_dout_valid (host_dout_valid),
      .host_tx_empty   (host_tx_empty),
      .err_flags       (err_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Record a check that failed outright (DUT produced a word nobody expected).
   task automatic flagUnexpected(input string name, input logic [31:0] act);
      checks++;
      failures++;
      $display("[TB] FAIL %s: got unexpected word 0x%08h expected none at %0t", name, act, $time);
   endtask

   // Advance the model over the upcoming clock edge using the inputs now driven.
   function automatic void modelStep();
      bit pop;
      bit push;
      bit tpop;
      bit treq;
      bit tfull;
      if (rst) begin
         m_rxq.delete();
         m_txq.delete();
         m_rxf_low    = 0;
         m_burst      = 0;
         m_gap        = 0;
         m_err        = '0;
         m_txe_n      = 1;
         m_full       = 0;
         m_empty      = 1;
         m_known      = 1;
         m_just_reset = 1;
         return;
      end
      m_just_reset = 0;

      pop  = !ft_oe_n && !ft_rd_n && m_rxf_low && (m_rxq.size() != 0);
      push = host_din_wr_en && ((m_rxq.size() < RX_DEPTH) || pop);
      if (pop) begin
         exp_rx.push_back(m_rxq.pop_front());
         m_burst++;
      end
      if (push) m_rxq.push_back(host_din);
      if (pop && (m_burst == MAX_BURST)) begin
         m_gap     = GAP_CYCLES;
         m_rxf_low = 0;
      end else if (m_gap > 0) begin
         m_gap--;
         m_rxf_low = (m_gap == 0) && (m_rxq.size() != 0);
      end else begin
         m_rxf_low = (m_rxq.size() != 0);
      end
      if (!m_rxf_low) m_burst = 0;
      m_full = (m_rxq.size() == RX_DEPTH);

      treq  = !ft_wr_n;
      tfull = (m_txq.size() == TX_DEPTH);
      tpop  = host_rd_en && (m_txq.size() != 0);
      if (treq && (ft_be != 4'hF)) m_err[3] = 1'b1;
      if (treq && tfull)           m_err[2] = 1'b1;
      if (!ft_wr_n && !ft_oe_n)    m_err[1] = 1'b1;
      if (!ft_rd_n && ft_oe_n)     m_err[0] = 1'b1;
      if (tpop) exp_tx.push_back(m_txq.pop_front());
      if (treq && !tfull) m_txq.push_back(ft_data_in);
      m_txe_n = ((TX_DEPTH - m_txq.size()) < TXE_SLACK);
      m_empty = (m_txq.size() == 0);
   endfunction

   // Drive one cycle of inputs just after the edge, latch the expectations for
   // this cycle, then let the model run over the coming edge.
   task automatic applyStimulus(input logic r, input logic [31:0] din, input logic dwr,
                                input logic oe, input logic rd, input logic wr,
                                input logic [3:0] be, input logic [31:0] fdata, input logic rden);
      @(posedge clk);
      #1;
      rst            = r;
      host_din       = din;
      host_din_wr_en = dwr;
      ft_oe_n        = oe;
      ft_rd_n        = rd;
      ft_wr_n        = wr;
      ft_be          = be;
      ft_data_in     = fdata;
      host_rd_en     = rden;
      s_known        = m_known;
      s_just_reset   = m_just_reset;
      s_rxf_n        = !m_rxf_low;
      s_txe_n        = m_txe_n;
      s_full         = m_full;
      s_empty        = m_empty;
      s_err          = m_err;
      modelStep();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1, 1, 1, 4'hF, 0, 0);
   endtask

   task automatic doReset(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 1, 1, 1, 4'hF, 0, 0);
   endtask

   task automatic hostPush(input logic [31:0] w);
      applyStimulus(0, w, 1, 1, 1, 1, 4'hF, 0, 0);
   endtask

   task automatic busRead(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 1, 4'hF, 0, 0);
   endtask

   // Monitor: status outputs every cycle, data on every handshake/valid pulse.
   always @(negedge clk) begin
      if (s_known) begin
         checkOutput("rxf_n",         32'(ft_rxf_n),      32'(s_rxf_n));
         checkOutput("txe_n",         32'(ft_txe_n),      32'(s_txe_n));
         checkOutput("host_din_full", 32'(host_din_full), 32'(s_full));
         checkOutput("host_tx_empty", 32'(host_tx_empty), 32'(s_empty));
         checkOutput("err_flags",     32'(err_flags),     32'(s_err));
         checkOutput("data_oe",       32'(ft_data_oe),    32'(!ft_oe_n));
         if (s_just_reset) begin
            checkOutput("host_dout_rst",   host_dout,             32'h0);
            checkOutput("dout_valid_rst",  32'(host_dout_valid),  32'h0);
            checkOutput("ft_data_out_rst", ft_data_out,           32'h0);
         end
         if (!rst && !ft_oe_n && !ft_rd_n && !ft_rxf_n) begin
            if (exp_rx.size() == 0) flagUnexpected("rx_pop", ft_data_out);
            else checkOutput("rx_data", ft_data_out, exp_rx.pop_front());
         end
         if (host_dout_valid) begin
            if (exp_tx.size() == 0) flagUnexpected("tx_pop", host_dout);
            else checkOutput("tx_data", host_dout, exp_tx.pop_front());
         end
      end
   end

   initial begin
      logic r;
      logic oe;
      logic rd;
      logic wr;
      logic [3:0] be;

      rst            = 1'b1;
      host_din       = '0;
      host_din_wr_en = 1'b0;
      ft_oe_n        = 1'b1;
      ft_rd_n        = 1'b1;
      ft_wr_n        = 1'b1;
      ft_be          = 4'hF;
      ft_data_in     = '0;
      host_rd_en     = 1'b0;
      ft_siwu_n      = 1'b1;

      $display("[TB] start");
      doReset(2);
      idle(2);

      // Three words out in order, RXF_N rises after the last pop.
      hostPush(32'h11223344);
      hostPush(32'h55667788);
      hostPush(32'h99AABBCC);
      idle(1);
      busRead(3);
      idle(3);

      // Twelve words with RD_N held: burst of 8, forced gap, then 4.
      for (int i = 0; i < 12; i++) hostPush(32'hA000_0000 + i);
      busRead(20);
      idle(2);

      // Seventeen TX strobes: 16 stored, TXE_N rises at 13, 17th overflows.
      for (int i = 0; i < 17; i++) applyStimulus(0, 0, 0, 1, 1, 0, 4'hF, i, 0);
      idle(2);
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 1, 1, 4'hF, 0, 1);
      idle(2);

      // Protocol errors: RD_N without OE_N, then a partial-BE write.
      doReset(1);
      idle(1);
      applyStimulus(0, 0, 0, 1, 0, 1, 4'hF, 0, 0);
      applyStimulus(0, 0, 0, 1, 1, 0, 4'h3, 32'hCAFE_0003, 0);
      idle(4);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1, 1, 4'hF, 0, 1);

      // Reset in the middle of a burst discards everything queued.
      doReset(1);
      for (int i = 0; i < 5; i++) hostPush(32'hB000_0000 + i);
      busRead(2);
      doReset(1);
      busRead(4);
      idle(2);

      // Fill RX, try one push at full, then push while popping at full.
      for (int i = 0; i < RX_DEPTH + 1; i++) hostPush(32'hC000_0000 + i);
      applyStimulus(0, 32'hC0DE_0000, 1, 0, 0, 1, 4'hF, 0, 0);
      busRead(40);
      idle(2);

      // Randomized traffic.
      doReset(1);
      for (int i = 0; i < 800; i++) begin
         r  = ($urandom_range(0, 99) == 0);
         oe = 1'($urandom_range(0, 1));
         rd = oe ? 1'b1 : ($urandom_range(0, 3) != 0 ? 1'b0 : 1'b1);
         if ($urandom_range(0, 49) == 0) begin
            oe = 1'b1;
            rd = 1'b0;
         end
         if (r) rd = 1'b1;
         wr = ($urandom_range(0, 2) != 0);
         be = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         applyStimulus(r, $urandom, 1'($urandom_range(0, 1)), oe, rd, wr, be,
                       $urandom, ($urandom_range(0, 2) == 0));
      end

      // Drain both directions, then confirm the scoreboards emptied.
      for (int i = 0; i < 60; i++) applyStimulus(0, 0, 0, 0, 0, 1, 4'hF, 0, 1);
      idle(3);
      @(negedge clk);
      #1;
      checkOutput("rx_scoreboard_drained", 32'(exp_rx.size()), 32'h0);
      checkOutput("tx_scoreboard_drained", 32'(exp_tx.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
